// File: rtl/acc_bank_if.sv
// acc_bank_if
// Bundles the increment port, the read port and the status outputs of
// acc_bank so the bank can be dropped into the tile through one port.
//
// Signals (direction as seen from the slave, i.e. the accumulator bank):
//   in_valid    in   increment request
//   in_ready    out  increment accepted this cycle when high with in_valid
//   in_ch       in   target channel of the increment
//   in_data     in   unsigned increment
//   sat_mode    in   1 = saturate on carry, 0 = wrap
//   clr_all     in   start the clear-all sweep
//   out_sel     in   read channel select
//   out_data    out  registered top bits of the selected accumulator
//   ovf         out  sticky per-channel overflow flags
//   carry_pulse out  one-cycle pulse after an add that carried out
//   carry_ch    out  channel of the most recent carry
interface acc_bank_if #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int NCH   = 4,
  parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
);

  logic             in_valid;
  logic             in_ready;
  logic [CH_W-1:0]  in_ch;
  logic [IN_W-1:0]  in_data;
  logic             sat_mode;
  logic             clr_all;
  logic [CH_W-1:0]  out_sel;
  logic [OUT_W-1:0] out_data;
  logic [NCH-1:0]   ovf;
  logic             carry_pulse;
  logic [CH_W-1:0]  carry_ch;

  modport master (
    output in_valid, in_ch, in_data, sat_mode, clr_all, out_sel,
    input  in_ready, out_data, ovf, carry_pulse, carry_ch
  );

  modport slave (
    input  in_valid, in_ch, in_data, sat_mode, clr_all, out_sel,
    output in_ready, out_data, ovf, carry_pulse, carry_ch
  );

endinterface

// File: rtl/acc_bank.sv
// acc_bank
// Bank of NCH independent unsigned ACC_W-bit accumulators. Increments
// arrive through a valid/ready port; the top OUT_W bits of the channel
// picked by out_sel are presented on a registered read port. Each channel
// carries a sticky overflow flag, any carrying add raises carry_pulse for
// one cycle, and clr_all starts a sweep that zeroes one channel per cycle.
//
// Build option:
//   ACC_SAT_EN  when defined, sat_mode=1 makes a carrying add saturate to
//               all-ones; when undefined sat_mode is ignored and every
//               carry wraps. ovf / carry_pulse behave the same either way.
//
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-high reset
//   bus  acc_bank_if slave modport (increment, read and status signals)
//
// State table:
//   state    | meaning
//   ST_IDLE  | accepting increments; clr_all here clears ch0 and starts sweep
//   ST_CLEAR | sweeping channels 1..NCH-1, one per cycle; increments blocked
module acc_bank #(
  parameter int ACC_W = 16,
  parameter int IN_W  = 8,
  parameter int OUT_W = 8,
  parameter int NCH   = 4,
  parameter int CH_W  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic       clk,
  input  logic       rst,
  acc_bank_if.slave  bus
);

  localparam logic [0:0]      ST_IDLE  = 1'b0;
  localparam logic [0:0]      ST_CLEAR = 1'b1;
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NCH - 1);

  logic [0:0]       state;
  logic [CH_W-1:0]  sweep_idx;
  logic [ACC_W-1:0] acc [NCH];
  logic [NCH-1:0]   ovf_q;
  logic [OUT_W-1:0] out_q;
  logic             carry_q;
  logic [CH_W-1:0]  carry_ch_q;

  logic             ready;
  logic             xfer;
  logic [NCH-1:0]   wr_hit;
  logic [NCH-1:0]   clr_hit;
  logic [ACC_W-1:0] wr_acc;
  logic [ACC_W-1:0] rd_acc;
  logic [ACC_W:0]   sum;
  logic             carry;
  logic             carry_evt;
  logic [ACC_W-1:0] acc_next;

  assign ready = (state == ST_IDLE) && !bus.clr_all;
  assign xfer  = bus.in_valid && ready;

  // Channel decode by compare rather than direct indexing, so an
  // out-of-range select (non-power-of-2 NCH) hits nothing: writes are
  // dropped and reads return zero.
  always_comb begin
    wr_hit  = '0;
    clr_hit = '0;
    wr_acc  = '0;
    rd_acc  = '0;
    for (int c = 0; c < NCH; c++) begin
      if (bus.in_ch == CH_W'(c)) begin
        wr_acc    = acc[c];
        wr_hit[c] = xfer;
      end
      if (bus.out_sel == CH_W'(c)) begin
        rd_acc = acc[c];
      end
      // The clr_all cycle itself clears channel 0, so the whole sweep
      // spans exactly NCH cycles of in_ready low.
      if (state == ST_IDLE) begin
        clr_hit[c] = bus.clr_all && (c == 0);
      end else begin
        clr_hit[c] = (sweep_idx == CH_W'(c));
      end
    end
  end

  assign sum       = {1'b0, wr_acc} + (ACC_W + 1)'(bus.in_data);
  assign carry     = sum[ACC_W];
  assign carry_evt = (|wr_hit) && carry;

`ifdef ACC_SAT_EN
  assign acc_next = (carry && bus.sat_mode) ? {ACC_W{1'b1}} : sum[ACC_W-1:0];
`else
  logic unused_sat_mode;
  assign unused_sat_mode = bus.sat_mode;
  assign acc_next        = sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      sweep_idx  <= '0;
      ovf_q      <= '0;
      out_q      <= '0;
      carry_q    <= 1'b0;
      carry_ch_q <= '0;
      for (int c = 0; c < NCH; c++) begin
        acc[c] <= '0;
      end
    end else begin
      out_q   <= rd_acc[ACC_W-1 -: OUT_W];
      carry_q <= carry_evt;
      if (carry_evt) begin
        carry_ch_q <= bus.in_ch;
      end

      for (int c = 0; c < NCH; c++) begin
        if (clr_hit[c]) begin
          acc[c]   <= '0;
          ovf_q[c] <= 1'b0;
        end else if (wr_hit[c]) begin
          acc[c] <= acc_next;
          if (carry) begin
            ovf_q[c] <= 1'b1;
          end
        end
      end

      case (state)
        ST_IDLE: begin
          if (bus.clr_all) begin
            state     <= ST_CLEAR;
            sweep_idx <= CH_W'(1);
          end
        end
        ST_CLEAR: begin
          if (sweep_idx == LAST_CH) begin
            state     <= ST_IDLE;
            sweep_idx <= '0;
          end else begin
            sweep_idx <= sweep_idx + CH_W'(1);
          end
        end
        default: begin
          state     <= ST_IDLE;
          sweep_idx <= '0;
        end
      endcase
    end
  end

  assign bus.in_ready    = ready;
  assign bus.out_data    = out_q;
  assign bus.ovf         = ovf_q;
  assign bus.carry_pulse = carry_q;
  assign bus.carry_ch    = carry_ch_q;

endmodule

// File: tb/tb_acc_bank.sv
module tb_acc_bank;

  localparam int ACC_W = 16;
  localparam int IN_W  = 8;
  localparam int OUT_W = 8;
  localparam int NCH   = 4;
  localparam int CH_W  = 2;

  typedef struct packed {
    logic [OUT_W-1:0] od;
    logic [NCH-1:0]   ov;
    logic             cp;
    logic [CH_W-1:0]  cc;
  } exp_t;

  logic clk;
  logic rst;

  acc_bank_if #(.IN_W(IN_W), .OUT_W(OUT_W), .NCH(NCH)) bus ();

  acc_bank #(.ACC_W(ACC_W), .IN_W(IN_W), .OUT_W(OUT_W), .NCH(NCH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model
  logic [ACC_W-1:0] m_acc [NCH];
  logic [NCH-1:0]   m_ovf;
  logic             m_cp;
  logic [CH_W-1:0]  m_cch;
  logic             m_clear;
  int               m_idx;
  exp_t             q_exp [$];

  // Expected ready before the edge, from model state and current inputs.
  function automatic logic exp_ready();
    return !m_clear && !bus.clr_all;
  endfunction

  // Advance the model by one edge using the currently driven inputs, push
  // the expected post-edge outputs, then step the DUT past the edge.
  task automatic tick();
    exp_t           e;
    logic [ACC_W:0] s;
    e.od = rst ? '0 : m_acc[bus.out_sel][ACC_W-1 -: OUT_W];
    m_cp = 1'b0;
    if (rst) begin
      for (int c = 0; c < NCH; c++) m_acc[c] = '0;
      m_ovf = '0; m_cch = '0; m_clear = 1'b0; m_idx = 0;
    end else if (m_clear) begin
      m_acc[m_idx] = '0;
      m_ovf[m_idx] = 1'b0;
      if (m_idx == NCH - 1) m_clear = 1'b0;
      else m_idx++;
    end else if (bus.clr_all) begin
      m_acc[0] = '0; m_ovf[0] = 1'b0; m_clear = 1'b1; m_idx = 1;
    end else if (bus.in_valid) begin
      s = {1'b0, m_acc[bus.in_ch]} + {{(ACC_W + 1 - IN_W){1'b0}}, bus.in_data};
      m_acc[bus.in_ch] = s[ACC_W-1:0];
      if (s[ACC_W]) begin
        m_ovf[bus.in_ch] = 1'b1;
        m_cp  = 1'b1;
        m_cch = bus.in_ch;
`ifdef ACC_SAT_EN
        if (bus.sat_mode) m_acc[bus.in_ch] = '1;
`endif
      end
    end
    e.ov = m_ovf; e.cp = m_cp; e.cc = m_cch;
    q_exp.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    bus.in_valid = 1'b0; bus.in_ch = '0; bus.in_data = '0;
    bus.sat_mode = 1'b0; bus.clr_all = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst = 1'b1;
    set_idle();
    bus.out_sel = '0;
    for (int k = 0; k < 3; k++) begin
      tick();
      e = q_exp.pop_front(); n_checks++;
      if ({bus.out_data, bus.ovf, bus.carry_pulse, bus.carry_ch} !== e) begin
        n_fail++;
        $display("FAIL reset_outputs: got od=%h ovf=%b cp=%b cch=%0d want %h %b %b %0d",
                 bus.out_data, bus.ovf, bus.carry_pulse, bus.carry_ch, e.od, e.ov, e.cp, e.cc);
      end
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b want 1", bus.in_ready);
    end
    tick();
    e = q_exp.pop_front(); n_checks++;
    if ({bus.out_data, bus.ovf, bus.carry_pulse, bus.carry_ch} !== 19'h0) begin
      n_fail++;
      $display("FAIL reset_hold: got od=%h ovf=%b cp=%b cch=%0d want all zero",
               bus.out_data, bus.ovf, bus.carry_pulse, bus.carry_ch);
    end
  endtask

  task automatic test_basic();
    exp_t e;
    bus.out_sel = '0;
    bus.in_valid = 1'b1; bus.in_ch = 2'd0; bus.in_data = 8'h80;
    for (int k = 0; k < 4; k++) begin
      if (k == 2) set_idle();
      tick();
      e = q_exp.pop_front(); n_checks++;
      if ({bus.out_data, bus.ovf, bus.carry_pulse, bus.carry_ch} !== e) begin
        n_fail++;
        $display("FAIL basic_sb: got od=%h ovf=%b cp=%b cch=%0d want %h %b %b %0d",
                 bus.out_data, bus.ovf, bus.carry_pulse, bus.carry_ch, e.od, e.ov, e.cp, e.cc);
      end
      if (k == 2) begin
        n_checks++;
        if (bus.out_data !== 8'h01) begin
          n_fail++; $display("FAIL basic_ch0: got %h want 01", bus.out_data);
        end
      end
    end
    for (int c = 1; c < NCH; c++) begin
      bus.out_sel = CH_W'(c);
      tick();
      e = q_exp.pop_front(); n_checks++;
      if (bus.out_data !== 8'h00 || bus.out_data !== e.od) begin
        n_fail++; $display("FAIL basic_other ch%0d: got %h want 00", c, bus.out_data);
      end
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    int   pulses = 0;
    bus.out_sel = 2'd2;
    bus.in_valid = 1'b1; bus.in_ch = 2'd2; bus.in_data = 8'h80; bus.sat_mode = 1'b0;
    for (int k = 0; k < 514; k++) begin
      if (k == 512) set_idle();
      tick();
      if (bus.carry_pulse === 1'b1) pulses++;
      e = q_exp.pop_front(); n_checks++;
      if ({bus.out_data, bus.ovf, bus.carry_pulse, bus.carry_ch} !== e) begin
        n_fail++;
        $display("FAIL wrap_sb k=%0d: got od=%h ovf=%b cp=%b cch=%0d want %h %b %b %0d", k,
                 bus.out_data, bus.ovf, bus.carry_pulse, bus.carry_ch, e.od, e.ov, e.cp, e.cc);
      end
    end
    n_checks++;
    if (pulses != 1 || bus.carry_ch !== 2'd2 || bus.ovf !== 4'b0100 || bus.out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL wrap_final: got pulses=%0d cch=%0d ovf=%b od=%h want 1 2 0100 00",
               pulses, bus.carry_ch, bus.ovf, bus.out_data);
    end
  endtask

  task automatic test_sat();
    exp_t e;
    int   pulses = 0;
    logic [OUT_W-1:0] want_od;
`ifdef ACC_SAT_EN
    want_od = 8'hFF;
`else
    want_od = 8'h00;
`endif
    bus.out_sel = 2'd1;
    bus.in_valid = 1'b1; bus.in_ch = 2'd1; bus.in_data = 8'hF0; bus.sat_mode = 1'b0;
    for (int k = 0; k < 277; k++) begin
      if (k == 273) begin bus.in_data = 8'h20; bus.sat_mode = 1'b1; end
      if (k == 274) set_idle();
      tick();
      if (bus.carry_pulse === 1'b1) pulses++;
      e = q_exp.pop_front(); n_checks++;
      if ({bus.out_data, bus.ovf, bus.carry_pulse, bus.carry_ch} !== e) begin
        n_fail++;
        $display("FAIL sat_sb k=%0d: got od=%h ovf=%b cp=%b cch=%0d want %h %b %b %0d", k,
                 bus.out_data, bus.ovf, bus.carry_pulse, bus.carry_ch, e.od, e.ov, e.cp, e.cc);
      end
      if (k == 272) begin
        n_checks++;
        if (bus.out_data !== 8'hFF) begin
          n_fail++; $display("FAIL sat_preload: got %h want ff", bus.out_data);
        end
      end
    end
    n_checks++;
    if (pulses != 1 || bus.out_data !== want_od || bus.ovf[1] !== 1'b1 || bus.carry_ch !== 2'd1) begin
      n_fail++;
      $display("FAIL sat_final: got pulses=%0d od=%h ovf1=%b cch=%0d want 1 %h 1 1",
               pulses, bus.out_data, bus.ovf[1], bus.carry_ch, want_od);
    end
  endtask

  task automatic test_clear();
    exp_t e;
    int   low = 0;
    bit   done = 0;
    // make ch2 and ch3 non-zero
    bus.in_valid = 1'b1; bus.in_ch = 2'd2; bus.in_data = 8'h80;
    tick(); void'(q_exp.pop_front());
    bus.in_ch = 2'd3; bus.in_data = 8'hFF;
    for (int k = 0; k < 3; k++) begin tick(); void'(q_exp.pop_front()); end
    bus.out_sel = 2'd3;
    bus.clr_all = 1'b1;
    for (int k = 0; k < 10 && !done; k++) begin
      #1;
      n_checks++;
      if (bus.in_ready !== exp_ready()) begin
        n_fail++; $display("FAIL clear_ready k=%0d: got %b want %b", k, bus.in_ready, exp_ready());
      end
      if (bus.in_ready === 1'b1) begin
        done = 1;
      end else begin
        low++;
        tick();
        e = q_exp.pop_front(); n_checks++;
        if ({bus.out_data, bus.ovf, bus.carry_pulse, bus.carry_ch} !== e) begin
          n_fail++;
          $display("FAIL clear_sb k=%0d: got od=%h ovf=%b cp=%b cch=%0d want %h %b %b %0d", k,
                   bus.out_data, bus.ovf, bus.carry_pulse, bus.carry_ch, e.od, e.ov, e.cp, e.cc);
        end
        n_checks++;
        if (bus.out_data !== 8'h02) begin
          n_fail++; $display("FAIL clear_ch3_visible k=%0d: got %h want 02", k, bus.out_data);
        end
        bus.clr_all = 1'b0;
      end
    end
    set_idle();
    n_checks++;
    if (low != NCH) begin
      n_fail++; $display("FAIL clear_low_cycles: got %0d want %0d", low, NCH);
    end
    for (int c = 0; c < NCH; c++) begin
      bus.out_sel = CH_W'(c);
      tick();
      e = q_exp.pop_front(); n_checks++;
      if (bus.out_data !== 8'h00 || bus.ovf !== 4'b0000 || bus.out_data !== e.od) begin
        n_fail++;
        $display("FAIL clear_after ch%0d: got od=%h ovf=%b want 00 0000", c, bus.out_data, bus.ovf);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    exp_t e;
    bus.out_sel = 2'd3;
    bus.in_valid = 1'b1; bus.in_ch = 2'd3; bus.in_data = 8'hFF;
    for (int k = 0; k < 258; k++) begin tick(); void'(q_exp.pop_front()); end
    set_idle();
    tick(); void'(q_exp.pop_front());
    n_checks++;
    if (bus.ovf !== 4'b1000 || bus.carry_ch !== 2'd3) begin
      n_fail++; $display("FAIL rsw_pre: got ovf=%b cch=%0d want 1000 3", bus.ovf, bus.carry_ch);
    end
    bus.clr_all = 1'b1;
    tick(); void'(q_exp.pop_front());
    bus.clr_all = 1'b0;
    tick(); void'(q_exp.pop_front());
    rst = 1'b1;
    tick();
    rst = 1'b0;
    e = q_exp.pop_front(); n_checks++;
    if ({bus.out_data, bus.ovf, bus.carry_pulse, bus.carry_ch} !== 19'h0 ||
        {bus.out_data, bus.ovf, bus.carry_pulse, bus.carry_ch} !== e) begin
      n_fail++;
      $display("FAIL rsw_outputs: got od=%h ovf=%b cp=%b cch=%0d want all zero",
               bus.out_data, bus.ovf, bus.carry_pulse, bus.carry_ch);
    end
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL rsw_ready: got %b want 1", bus.in_ready);
    end
    tick();
    e = q_exp.pop_front(); n_checks++;
    if (bus.out_data !== 8'h00 || bus.out_data !== e.od) begin
      n_fail++; $display("FAIL rsw_ch3: got %h want 00", bus.out_data);
    end
  endtask

  task automatic test_stress();
    exp_t e;
    int   bad = 0;
    for (int k = 0; k < 10000; k++) begin
      bus.in_valid = ($urandom_range(0, 3) != 0);
      bus.in_ch    = CH_W'($urandom_range(0, NCH - 1));
      bus.in_data  = IN_W'($urandom);
      bus.out_sel  = CH_W'($urandom_range(0, NCH - 1));
      bus.sat_mode = $urandom_range(0, 1) == 1;
      bus.clr_all  = ($urandom_range(0, 63) == 0);
      rst          = ($urandom_range(0, 999) == 0);
      #1;
      if (!rst) begin
        n_checks++;
        if (bus.in_ready !== exp_ready()) begin
          n_fail++; bad++;
          if (bad < 10) $display("FAIL stress_ready k=%0d: got %b want %b", k, bus.in_ready, exp_ready());
        end
      end
      tick();
      e = q_exp.pop_front(); n_checks++;
      if ({bus.out_data, bus.ovf, bus.carry_pulse, bus.carry_ch} !== e) begin
        n_fail++; bad++;
        if (bad < 10)
          $display("FAIL stress_sb k=%0d: got od=%h ovf=%b cp=%b cch=%0d want %h %b %b %0d", k,
                   bus.out_data, bus.ovf, bus.carry_pulse, bus.carry_ch, e.od, e.ov, e.cp, e.cc);
      end
    end
    rst = 1'b0;
    set_idle();
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) m_acc[c] = '0;
    m_ovf = '0; m_cp = 1'b0; m_cch = '0; m_clear = 1'b0; m_idx = 0;
    rst = 1'b1;
    set_idle();
    bus.out_sel = '0;
    test_reset();
    test_basic();
    test_wrap();
    test_sat();
    test_clear();
    test_reset_mid_sweep();
    test_stress();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
